// File: rtl/downsample_pkg.sv
// Shared types and width helpers for the 2-D downsampler.
package downsample_pkg;

  typedef enum logic {
    DS_DECIMATE = 1'b0,
    DS_AVERAGE  = 1'b1
  } ds_mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } ds_state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Per-channel accumulator width: enough headroom for a full H x V block sum.
  function automatic int acc_width(input int pw, input int hf, input int vf);
    return pw + clog2(hf * vf);
  endfunction

  // Output pixels per line.
  function automatic int out_cols(input int img_w, input int hf);
    return img_w / hf;
  endfunction

endpackage

// File: rtl/ds_line_acc.sv
// Line accumulator: one entry per output column holding the running vertical
// sum of horizontal block sums. Combinational read, synchronous write.
module ds_line_acc
  import downsample_pkg::*;
#(
  parameter int CH       = 3,
  parameter int ACC_W    = 10,
  parameter int OUT_COLS = 320,
  parameter int AW       = 9
) (
  input  logic                clk,
  input  logic [AW-1:0]       addr_i,
  input  logic                wr_en_i,
  input  logic                first_i,
  input  logic [CH*ACC_W-1:0] wdata_i,
  output logic [CH*ACC_W-1:0] sum_o
);

  logic [CH*ACC_W-1:0] mem_q [OUT_COLS];
  logic [CH*ACC_W-1:0] rd;

  assign rd = mem_q[addr_i];

  // First line of a block overwrites the entry, later lines add into it.
  for (genvar c = 0; c < CH; c++) begin : g_ch
    assign sum_o[c*ACC_W +: ACC_W] = first_i ? wdata_i[c*ACC_W +: ACC_W]
                                             : rd[c*ACC_W +: ACC_W] + wdata_i[c*ACC_W +: ACC_W];
  end

  // Store the updated column sum; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[addr_i] <= sum_o;
  end

endmodule

// File: rtl/downsample_2d.sv
// Raster-scan 2-D downsampler (decimate or box-average) with valid/ready on
// both sides. Define DS_ROUND_EN to round averages half-up instead of truncating.
module downsample_2d
  import downsample_pkg::*;
#(
  parameter int PW       = 8,
  parameter int CH       = 3,
  parameter int H_FACTOR = 2,
  parameter int V_FACTOR = 2,
  parameter int IMG_W    = 640
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_avg,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [CH*PW-1:0] s_data,
  input  logic             s_sof,
  input  logic             s_eol,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CH*PW-1:0] m_data,
  output logic             m_sof,
  output logic             m_eol,
  output logic             err
);

  localparam int SH       = clog2(H_FACTOR * V_FACTOR);
  localparam int ACC_W    = acc_width(PW, H_FACTOR, V_FACTOR);
  localparam int OUT_COLS = out_cols(IMG_W, H_FACTOR);
  localparam int HW       = (H_FACTOR > 1) ? clog2(H_FACTOR) : 1;
  localparam int VW       = (V_FACTOR > 1) ? clog2(V_FACTOR) : 1;
  localparam int AW       = (OUT_COLS > 1) ? clog2(OUT_COLS) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(H_FACTOR - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_FACTOR - 1);
  localparam logic [AW-1:0] C_LAST = AW'(OUT_COLS - 1);
`ifdef DS_ROUND_EN
  localparam logic [ACC_W:0] RND = (ACC_W + 1)'((1 << SH) >> 1);
`else
  localparam logic [ACC_W:0] RND = '0;
`endif

  ds_state_e           state_q;
  ds_mode_e            mode_q;
  logic [HW-1:0]       hcnt_q;
  logic [VW-1:0]       vcnt_q;
  logic [AW-1:0]       col_q;
  logic                ovf_q;    // line ran past IMG_W, discarding until s_eol
  logic                first_q;  // next output is the first of the frame
  logic                err_q;
  logic [CH*ACC_W-1:0] hsum_q;

  logic                mv_q, msof_q, meol_q;
  logic [CH*PW-1:0]    md_q;

  logic                acc, sof, take, xtra, bad_eol, use_px, emit, wr_en;
  logic                last_h, last_v, last_c;
  logic [HW-1:0]       h_e;
  logic [VW-1:0]       v_e;
  logic [AW-1:0]       c_e;
  ds_mode_e            mode_e;
  logic [CH*ACC_W-1:0] hsum_d, blk_sum;
  logic [CH*PW-1:0]    avg_px, m_data_d;

  assign s_ready = !mv_q || m_ready;
  assign m_valid = mv_q;
  assign m_data  = md_q;
  assign m_sof   = msof_q;
  assign m_eol   = meol_q;
  assign err     = err_q;

  // Effective position of the current pixel; an accepted SOF restarts at (0,0).
  always_comb begin
    acc     = s_valid && s_ready;
    sof     = acc && s_sof;
    take    = acc && (sof || state_q == ST_ACTIVE);
    h_e     = sof ? '0 : hcnt_q;
    v_e     = sof ? '0 : vcnt_q;
    c_e     = sof ? '0 : col_q;
    mode_e  = sof ? ds_mode_e'(cfg_avg) : mode_q;
    last_h  = (h_e == H_LAST);
    last_v  = (v_e == V_LAST);
    last_c  = (c_e == C_LAST);
    xtra    = take && !sof && ovf_q;
    bad_eol = s_eol && !(last_h && last_c);
    use_px  = take && !xtra && !bad_eol;
    emit    = use_px && ((mode_e == DS_AVERAGE) ? (last_h && last_v)
                                                : (h_e == '0 && v_e == '0));
    wr_en   = use_px && (mode_e == DS_AVERAGE) && last_h;
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [ACC_W-1:0] base, pix;
    logic [ACC_W:0]   rsum;
    assign pix  = ACC_W'(s_data[c*PW +: PW]);
    assign base = (h_e == '0) ? '0 : hsum_q[c*ACC_W +: ACC_W];
    assign hsum_d[c*ACC_W +: ACC_W] = base + pix;
    assign rsum = {1'b0, blk_sum[c*ACC_W +: ACC_W]} + RND;
    assign avg_px[c*PW +: PW] = PW'(rsum >> SH);
  end

  assign m_data_d = (mode_e == DS_AVERAGE) ? avg_px : s_data;

  ds_line_acc #(
    .CH(CH), .ACC_W(ACC_W), .OUT_COLS(OUT_COLS), .AW(AW)
  ) u_acc (
    .clk     (clk),
    .addr_i  (c_e),
    .wr_en_i (wr_en),
    .first_i (v_e == '0),
    .wdata_i (hsum_d),
    .sum_o   (blk_sum)
  );

  // Frame state, raster counters, horizontal sums and the sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= DS_DECIMATE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      col_q   <= '0;
      ovf_q   <= 1'b0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
      hsum_q  <= '0;
    end else if (take) begin
      state_q <= ST_ACTIVE;
      mode_q  <= mode_e;
      err_q   <= (err_q && !sof) || xtra || bad_eol;
      first_q <= (sof || first_q) && !emit;
      if (use_px) hsum_q <= hsum_d;
      hcnt_q  <= h_e;
      col_q   <= c_e;
      vcnt_q  <= v_e;
      ovf_q   <= ovf_q && !sof;
      if (s_eol) begin
        // every line end realigns, even a malformed one
        hcnt_q <= '0;
        col_q  <= '0;
        vcnt_q <= last_v ? '0 : v_e + 1'b1;
        ovf_q  <= 1'b0;
      end else if (!xtra) begin
        if (last_h) begin
          hcnt_q <= '0;
          col_q  <= last_c ? '0 : c_e + 1'b1;
          ovf_q  <= last_c;
        end else begin
          hcnt_q <= h_e + 1'b1;
        end
      end
    end
  end

  // Single output register; holds while the sink stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv_q   <= 1'b0;
      md_q   <= '0;
      msof_q <= 1'b0;
      meol_q <= 1'b0;
    end else if (emit) begin
      mv_q   <= 1'b1;
      md_q   <= m_data_d;
      msof_q <= sof || first_q;
      meol_q <= last_c;
    end else if (m_ready) begin
      mv_q   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_downsample_2d.sv
// Directed bench for downsample_2d: 2 channels (ch1 = ch0 + 100), 2x2, IMG_W = 4.
module tb_downsample_2d;

  logic        clk, rst_n, cfg_avg;
  logic        s_valid, s_ready, s_sof, s_eol;
  logic [15:0] s_data, m_data;
  logic        m_valid, m_ready, m_sof, m_eol, err;

  int checks = 0;
  int fails  = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int vals[8];

  downsample_2d #(
    .PW(8), .CH(2), .H_FACTOR(2), .V_FACTOR(2), .IMG_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_avg(cfg_avg),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // capture every transfer
  always @(negedge clk)
    if (m_valid && m_ready) got_q.push_back({14'd0, m_data, m_sof, m_eol});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pxw(input int v);
    return {8'(v + 100), 8'(v)};
  endfunction

  function automatic logic [31:0] ent(input int v, input bit sof, input bit eol);
    return {14'd0, pxw(v), sof, eol};
  endfunction

  task automatic send_px(input int v, input bit sof, input bit eol);
    int n;
    s_valid = 1'b1; s_data = pxw(v); s_sof = sof; s_eol = eol;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 50) begin @(negedge clk); n++; end
    if (!s_ready) chk("s_ready_timeout", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
  endtask

  task automatic send_row(input int r, input int n, input bit sof, input bit eol);
    for (int c = 0; c < n; c++) send_px(10 * r + c, sof && c == 0, eol && c == n - 1);
  endtask

  task automatic send_arr(input int n, input bit sof);
    for (int c = 0; c < n; c++) send_px(vals[c], sof && c == 0, c == n - 1);
  endtask

  task automatic dec_frame();
    cfg_avg = 1'b0;
    for (int r = 0; r < 4; r++) send_row(r, 4, r == 0, 1'b1);
  endtask

  task automatic exp_dec_frame();
    exp_q.push_back(ent(0, 1, 0));  exp_q.push_back(ent(2, 0, 1));
    exp_q.push_back(ent(20, 0, 0)); exp_q.push_back(ent(22, 0, 1));
  endtask

  task automatic check_outs(input string tag);
    repeat (6) @(posedge clk);
    #1;
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk($sformatf("%s_%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; cfg_avg = 1'b0; s_valid = 1'b0; s_data = '0;
    s_sof = 1'b0; s_eol = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data",  32'(m_data),  32'd0);
    chk("rst_m_flags", {30'd0, m_sof, m_eol}, 32'd0);
    chk("rst_err",     32'(err),     32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);

    // decimate 4x4
    dec_frame();
    exp_dec_frame();
    check_outs("dec");
    chk("dec_err", 32'(err), 32'd0);

    // average 2x2 over two block rows
    cfg_avg = 1'b1;
    vals = '{10, 20, 30, 40, 0, 0, 0, 0}; send_arr(4, 1'b1);
    vals = '{30, 40, 50, 60, 0, 0, 0, 0}; send_arr(4, 1'b0);
    vals = '{1, 2, 0, 0, 0, 0, 0, 0};     send_arr(4, 1'b0);
    vals = '{2, 2, 0, 0, 0, 0, 0, 0};     send_arr(4, 1'b0);
    exp_q.push_back(ent(25, 1, 0));
    exp_q.push_back(ent(45, 0, 1));
`ifdef DS_ROUND_EN
    exp_q.push_back(ent(2, 0, 0));
`else
    exp_q.push_back(ent(1, 0, 0));
`endif
    exp_q.push_back(ent(0, 0, 1));
    check_outs("avg");

    // backpressure: stall the first output for 5 cycles
    fork
      dec_frame();
      begin
        int n;
        n = 0;
        @(posedge clk); #2;
        while (!m_valid && n < 50) begin @(posedge clk); #2; n++; end
        chk("bp_valid", 32'(m_valid), 32'd1);
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("bp_hold_data", 32'(m_data), 32'(pxw(0)));
          chk("bp_s_ready", 32'(s_ready), 32'd0);
          @(posedge clk); #2;
        end
        m_ready = 1'b1;
      end
    join
    exp_dec_frame();
    check_outs("bp");

    // short line: row 0 ends after 3 pixels
    cfg_avg = 1'b0;
    send_row(0, 3, 1'b1, 1'b1);
    chk("short_err", 32'(err), 32'd1);
    send_row(1, 4, 1'b0, 1'b1);
    send_row(2, 4, 1'b0, 1'b1);
    exp_q.push_back(ent(0, 1, 0));
    exp_q.push_back(ent(20, 0, 0)); exp_q.push_back(ent(22, 0, 1));
    check_outs("short");

    // long line: row 0 carries 6 pixels, extras dropped
    send_row(0, 6, 1'b1, 1'b1);
    chk("long_err_clr_then_set", 32'(err), 32'd1);
    send_row(1, 4, 1'b0, 1'b1);
    send_row(2, 4, 1'b0, 1'b1);
    exp_q.push_back(ent(0, 1, 0));  exp_q.push_back(ent(2, 0, 1));
    exp_q.push_back(ent(20, 0, 0)); exp_q.push_back(ent(22, 0, 1));
    check_outs("long");

    // mid-frame SOF with mode toggles: avg (err) -> decimate -> avg
    cfg_avg = 1'b1;
    vals = '{90, 90, 90, 0, 0, 0, 0, 0}; send_arr(3, 1'b1);
    send_px(90, 1'b0, 1'b0);
    chk("msof_err_set", 32'(err), 32'd1);
    cfg_avg = 1'b0;
    send_row(5, 1, 1'b1, 1'b0);
    chk("msof_err_clr", 32'(err), 32'd0);
    cfg_avg = 1'b1;
    vals = '{10, 20, 30, 40, 0, 0, 0, 0}; send_arr(4, 1'b1);
    vals = '{30, 40, 50, 60, 0, 0, 0, 0}; send_arr(4, 1'b0);
    exp_q.push_back(ent(50, 1, 0));
    exp_q.push_back(ent(25, 1, 0));
    exp_q.push_back(ent(45, 0, 1));
    check_outs("msof");

    // asynchronous reset mid-line while an output is stalled
    m_ready = 1'b0;
    cfg_avg = 1'b0;
    send_px(0, 1'b1, 1'b0);
    chk("arst_pre_valid", 32'(m_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(m_valid), 32'd0);
    chk("arst_data",  32'(m_data),  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_ready = 1'b1;
    send_row(1, 4, 1'b0, 1'b1);
    send_row(2, 4, 1'b0, 1'b1);
    check_outs("idle_discard");
    dec_frame();
    exp_dec_frame();
    check_outs("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
